// File: rtl/lsu_pipe.sv
// Load/store unit pipe: one outstanding bus access, byte-lane steering,
// load extension, misalignment checking and a WAIT-state timeout.
module lsu_pipe #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [1:0]          req_size,
    input  logic                req_signed,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LANE_W = $clog2(STRB_W);
    localparam int CNT_W  = 16;
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(STRB_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic                sgn_q, sgn_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic [LANE_W-1:0]   req_lane_s;
    logic                req_bad_s;
    logic [CNT_W-1:0]    cnt_inc_s;

    function automatic logic is_misaligned(input logic [2:0] low, input logic [1:0] size);
        logic r;
        case (size)
            2'd0:    r = 1'b0;
            2'd1:    r = low[0];
            2'd2:    r = |low[1:0];
            2'd3:    r = |low[2:0];
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [STRB_W-1:0] strb_base(input logic [1:0] size);
        logic [STRB_W-1:0] r;
        case (size)
            2'd0:    r = STRB_W'(8'h01);
            2'd1:    r = STRB_W'(8'h03);
            2'd2:    r = STRB_W'(8'h0F);
            2'd3:    r = STRB_W'(8'hFF);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Shift the addressed bytes down, keep 2^size bytes, then sign/zero extend.
    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] raw,
                                                   input logic [LANE_W-1:0] lane,
                                                   input logic [1:0]        size,
                                                   input logic              sgn);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] mask;
        logic              sb;
        logic [DATA_W-1:0] r;
        sh = raw >> {lane, 3'b000};
        case (size)
            2'd0: begin
                mask = DATA_W'(64'h0000_0000_0000_00FF);
                sb   = sh[7];
            end
            2'd1: begin
                mask = DATA_W'(64'h0000_0000_0000_FFFF);
                sb   = sh[15];
            end
            2'd2: begin
                mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
                sb   = sh[31];
            end
            default: begin
                mask = '1;
                sb   = sh[DATA_W-1];
            end
        endcase
        r = sh & mask;
        if (sgn && sb) begin
            r = r | ~mask;
        end else begin
            r = r;
        end
        return r;
    endfunction

    assign req_lane_s = req_addr[LANE_W-1:0];
    assign req_bad_s  = is_misaligned(req_addr[2:0], req_size) ||
                        ((req_size == 2'd3) && (DATA_W != 64));
    assign cnt_inc_s  = cnt_q + 16'd1;

    // Next-state and next-output computation for the access FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        lane_d       = lane_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    size_d = req_size;
                    sgn_d  = req_signed;
                    lane_d = req_lane_s;
                    if (req_bad_s) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d     = ST_ISSUE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = req_addr & ~LANE_MASK;
                        mem_wstrb_d = req_we ? (strb_base(req_size) << req_lane_s) : '0;
                        mem_wdata_d = req_we ? (req_wdata << {req_lane_s, 3'b000}) : '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_gnt) begin
                    state_d   = ST_WAIT;
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // A completion in the timeout cycle still wins.
                if (mem_rvalid) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = mem_err;
                    resp_rdata_d = (mem_err || we_q) ? '0 : load_ext(mem_rdata, lane_q, size_q, sgn_q);
                    mem_we_d     = 1'b0;
                    mem_addr_d   = '0;
                    mem_wdata_d  = '0;
                    mem_wstrb_d  = '0;
                end else if (cnt_inc_s == TIMEOUT_C) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = '0;
                    mem_wdata_d  = '0;
                    mem_wstrb_d  = '0;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
                mem_req_d    = 1'b0;
            end
        endcase
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            size_q       <= 2'd0;
            sgn_q        <= 1'b0;
            lane_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            lane_q       <= lane_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe: a 32-bit instance (TIMEOUT=4) and a 64-bit
// instance share stimulus; sel_b picks which one is driven and observed.
module tb_lsu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, sel_b;
    logic        req_we, req_signed;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        resp_ready, mem_gnt, mem_rvalid, mem_err;
    logic [63:0] mem_rdata;

    logic        req_ready_a, resp_valid_a, resp_err_a, mem_req_a, mem_we_a;
    logic [31:0] resp_rdata_a, mem_addr_a, mem_wdata_a;
    logic [3:0]  mem_wstrb_a;
    logic        req_ready_b, resp_valid_b, resp_err_b, mem_req_b, mem_we_b;
    logic [63:0] resp_rdata_b, mem_wdata_b;
    logic [31:0] mem_addr_b;
    logic [7:0]  mem_wstrb_b;

    logic        valid_a, valid_b;
    logic        rdy_o, rv_o, re_o, mreq_o, mwe_o;
    logic [63:0] rd_o, mwd_o;
    logic [31:0] maddr_o;
    logic [7:0]  mst_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign valid_a = req_valid & ~sel_b;
    assign valid_b = req_valid & sel_b;
    assign rdy_o   = sel_b ? req_ready_b  : req_ready_a;
    assign rv_o    = sel_b ? resp_valid_b : resp_valid_a;
    assign re_o    = sel_b ? resp_err_b   : resp_err_a;
    assign mreq_o  = sel_b ? mem_req_b    : mem_req_a;
    assign mwe_o   = sel_b ? mem_we_b     : mem_we_a;
    assign rd_o    = sel_b ? resp_rdata_b : {32'h0, resp_rdata_a};
    assign mwd_o   = sel_b ? mem_wdata_b  : {32'h0, mem_wdata_a};
    assign maddr_o = sel_b ? mem_addr_b   : mem_addr_a;
    assign mst_o   = sel_b ? mem_wstrb_b  : {4'h0, mem_wstrb_a};

    lsu_pipe #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid_a), .req_ready(req_ready_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_size(req_size),
        .req_signed(req_signed),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
        .mem_req(mem_req_a), .mem_gnt(mem_gnt), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_wstrb(mem_wstrb_a),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]), .mem_err(mem_err)
    );

    lsu_pipe #(.ADDR_W(32), .DATA_W(64)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid_b), .req_ready(req_ready_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
        .mem_req(mem_req_b), .mem_gnt(mem_gnt), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wstrb(mem_wstrb_b),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_rdy"},   rdy_o,   64'd1);
        check_val({tag, "_rv"},    rv_o,    64'd0);
        check_val({tag, "_err"},   re_o,    64'd0);
        check_val({tag, "_rdata"}, rd_o,    64'd0);
        check_val({tag, "_mreq"},  mreq_o,  64'd0);
        check_val({tag, "_mwe"},   mwe_o,   64'd0);
        check_val({tag, "_mstrb"}, mst_o,   64'd0);
        check_val({tag, "_maddr"}, maddr_o, 64'd0);
        check_val({tag, "_mwd"},   mwd_o,   64'd0);
    endtask

    // Full legal access: accept, optional grant delay, rvalid, stalled response, handshake.
    task automatic access(input logic b, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic sgn, input logic [63:0] wdata,
                          input logic [63:0] rdata, input logic err, input int gnt_dly,
                          input logic [31:0] e_addr, input logic [7:0] e_strb,
                          input logic [63:0] e_wdata, input logic [63:0] e_rdata,
                          input logic e_err);
        sel_b = b; req_we = we; req_addr = addr; req_size = size;
        req_signed = sgn; req_wdata = wdata; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check_val("issue_req",   mreq_o,  64'd1);
        check_val("issue_rdy",   rdy_o,   64'd0);
        check_val("issue_we",    mwe_o,   {63'd0, we});
        check_val("issue_addr",  maddr_o, {32'd0, e_addr});
        check_val("issue_strb",  mst_o,   {56'd0, e_strb});
        check_val("issue_wdata", mwd_o,   e_wdata);
        for (int i = 0; i < gnt_dly; i++) begin
            step();
            check_val("hold_req", mreq_o, 64'd1);
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check_val("wait_req", mreq_o, 64'd0);
        check_val("wait_rv",  rv_o,   64'd0);
        mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
        step();
        mem_rvalid = 1'b0; mem_rdata = 64'd0; mem_err = 1'b0;
        check_val("resp_rv",    rv_o, 64'd1);
        check_val("resp_err",   re_o, {63'd0, e_err});
        check_val("resp_rdata", rd_o, e_rdata);
        step();
        check_val("stall_rv",    rv_o, 64'd1);
        check_val("stall_rdata", rd_o, e_rdata);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check_val("done_rv",  rv_o,  64'd0);
        check_val("done_rdy", rdy_o, 64'd1);
    endtask

    // Misaligned or illegal request: immediate error response, bus never requested.
    task automatic bad_req(input logic b, input logic [31:0] addr, input logic [1:0] size);
        sel_b = b; req_we = 1'b0; req_addr = addr; req_size = size;
        req_signed = 1'b0; req_valid = 1'b1; mem_gnt = 1'b1;
        step();
        req_valid = 1'b0;
        check_val("bad_rv",    rv_o,   64'd1);
        check_val("bad_err",   re_o,   64'd1);
        check_val("bad_rdata", rd_o,   64'd0);
        check_val("bad_mreq",  mreq_o, 64'd0);
        step();
        check_val("bad_mreq2", mreq_o, 64'd0);
        mem_gnt = 1'b0; resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check_val("bad_done", rv_o, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; sel_b = 1'b0; req_we = 1'b0;
        req_signed = 1'b0; req_addr = 32'd0; req_wdata = 64'd0; req_size = 2'd0;
        resp_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
        mem_rdata = 64'd0;
        step();
        step();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        access(1'b0, 1'b0, 32'h8000_0003, 2'd0, 1'b1, 64'd0, 64'h0000_0000_80FF_FFFF, 1'b0, 0,
               32'h8000_0000, 8'h00, 64'd0, 64'h0000_0000_FFFF_FF80, 1'b0);
        access(1'b0, 1'b1, 32'h0000_1002, 2'd1, 1'b0, 64'h0000_0000_0000_BEEF, 64'h0000_0000_FFFF_FFFF, 1'b0, 2,
               32'h0000_1000, 8'h0C, 64'h0000_0000_BEEF_0000, 64'd0, 1'b0);
        access(1'b0, 1'b0, 32'h0000_0002, 2'd1, 1'b0, 64'd0, 64'h0000_0000_8001_1234, 1'b0, 0,
               32'h0000_0000, 8'h00, 64'd0, 64'h0000_0000_0000_8001, 1'b0);
        access(1'b0, 1'b0, 32'h0000_0005, 2'd0, 1'b0, 64'd0, 64'h0000_0000_0000_AB00, 1'b1, 1,
               32'h0000_0004, 8'h00, 64'd0, 64'd0, 1'b1);
        access(1'b0, 1'b1, 32'h0000_0007, 2'd0, 1'b0, 64'h0000_0000_0000_00A5, 64'd0, 1'b0, 0,
               32'h0000_0004, 8'h08, 64'h0000_0000_A500_0000, 64'd0, 1'b0);
        access(1'b0, 1'b0, 32'h0000_0008, 2'd2, 1'b1, 64'd0, 64'h0000_0000_8000_0000, 1'b0, 0,
               32'h0000_0008, 8'h00, 64'd0, 64'h0000_0000_8000_0000, 1'b0);
        access(1'b1, 1'b0, 32'h0000_1004, 2'd2, 1'b0, 64'd0, 64'h8765_4321_0000_0000, 1'b0, 0,
               32'h0000_1000, 8'h00, 64'd0, 64'h0000_0000_8765_4321, 1'b0);
        access(1'b1, 1'b1, 32'h0000_2000, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 0,
               32'h0000_2000, 8'hFF, 64'h1122_3344_5566_7788, 64'd0, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0006, 2'd1, 1'b1, 64'd0, 64'hFEDC_0000_0000_0000, 1'b0, 0,
               32'h0000_0000, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FEDC, 1'b0);

        bad_req(1'b0, 32'h0000_1002, 2'd2);
        bad_req(1'b0, 32'h0000_1001, 2'd1);
        bad_req(1'b0, 32'h0000_1000, 2'd3);
        bad_req(1'b1, 32'h0000_1004, 2'd3);

        // Timeout: error exactly 4 cycles after the grant; late rvalid ignored.
        sel_b = 1'b0; req_we = 1'b0; req_addr = 32'h0000_0100; req_size = 2'd2; req_valid = 1'b1;
        step();
        req_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("to_early", rv_o, 64'd0);
        end
        step();
        check_val("to_rv",    rv_o, 64'd1);
        check_val("to_err",   re_o, 64'd1);
        check_val("to_rdata", rd_o, 64'd0);
        mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_FFFF_FFFF;
        step();
        mem_rvalid = 1'b0; mem_rdata = 64'd0;
        check_val("to_stray_err",   re_o, 64'd1);
        check_val("to_stray_rdata", rd_o, 64'd0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check_val("idle_stray_rv", rv_o,  64'd0);
        check_val("idle_rdy",      rdy_o, 64'd1);

        // rvalid on the would-be timeout cycle wins.
        req_addr = 32'h0000_0010; req_size = 2'd2; req_valid = 1'b1;
        step();
        req_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
        end
        mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_1234_5678;
        step();
        mem_rvalid = 1'b0; mem_rdata = 64'd0;
        check_val("prio_rv",    rv_o, 64'd1);
        check_val("prio_err",   re_o, 64'd0);
        check_val("prio_rdata", rd_o, 64'h0000_0000_1234_5678);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Reset in WAIT aborts the store; completion after release is ignored.
        req_we = 1'b1; req_addr = 32'h0000_0040; req_size = 2'd2;
        req_wdata = 64'h0000_0000_CAFE_F00D; req_valid = 1'b1;
        step();
        req_valid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check_val("pre_rst_we", mwe_o, 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step();
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check_val("post_rst_rv",   rv_o,   64'd0);
        check_val("post_rst_rdy",  rdy_o,  64'd1);
        check_val("post_rst_mreq", mreq_o, 64'd0);
        step();
        check_val("post_rst_rv2",  rv_o,   64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
